// File: rtl/nes_video_rx.sv
// nes_video_rx: pixel-bus timing checker with lock detection, pixel recovery and per-frame signature
module nes_video_rx #(
  parameter logic [11:0] EXP_H_ACTIVE = 12'd1920,
  parameter logic [11:0] EXP_V_ACTIVE = 12'd1080,
  parameter logic [11:0] EXP_H_TOTAL  = 12'd2200,
  parameter logic [11:0] EXP_V_TOTAL  = 12'd1125,
  parameter logic [3:0]  LOCK_FRAMES  = 4'd2
) (
  input  logic        clk_pixel,
  input  logic        rst_pixel,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [35:0] video,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_done,
  output logic [11:0] h_active,
  output logic [11:0] v_active,
  output logic [11:0] h_total,
  output logic [11:0] v_total,
  output logic [31:0] frame_sig,
  output logic        frame_ok,
  output logic        locked,
  output logic [7:0]  err_count
);
  typedef enum logic {HUNT, TRACK} state_t;
  state_t state, state_d;
  logic de1, hs1, vs1, de2, hs2, vs2, h_seen, bad, bad_n;
  logic hs_rise, vs_rise, de_fall, ok_n, emit, unused_pad;
  logic [23:0] rgb1;
  logic [11:0] hcnt, dcnt, vcnt, lcnt, h_active_run, h_total_run;
  logic [11:0] vcnt_n, lcnt_n, hact_n, htot_n;
  logic [31:0] sig, sig_base, sig_n;
  logic [3:0] gcnt, gcnt_n;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return v == 12'hfff ? v : v + 12'd1;
  endfunction

  // The "_n" values already include this cycle's hsync/de_fall updates, so a
  // coincident vsync rise reports them before the running state is cleared.
  always_comb begin
    unused_pad = ^{video[27:24], video[15:12], video[3:0]};
    hs_rise = hs1 & ~hs2;
    vs_rise = vs1 & ~vs2;
    de_fall = ~de1 & de2;
    bad_n = bad | (hs_rise & h_seen & (hcnt != EXP_H_TOTAL)) | (de_fall & (dcnt != EXP_H_ACTIVE));
    vcnt_n = hs_rise ? sat_inc(vcnt) : vcnt;
    lcnt_n = de_fall ? sat_inc(lcnt) : lcnt;
    hact_n = de_fall ? dcnt : h_active_run;
    htot_n = hs_rise ? hcnt : h_total_run;
    sig_base = vs_rise ? 32'd0 : sig;
    sig_n = de1 ? ({sig_base[30:0], sig_base[31]} ^ {8'h00, rgb1}) : sig_base;
    ok_n = ~bad_n & (lcnt_n == EXP_V_ACTIVE) & (vcnt_n == EXP_V_TOTAL);
    gcnt_n = ok_n ? (gcnt == LOCK_FRAMES ? gcnt : gcnt + 4'd1) : 4'd0;
    state_d = vs_rise ? TRACK : state;
    emit = vs_rise & (state == TRACK);
  end

  always_ff @(posedge clk_pixel)
    if (rst_pixel) state <= HUNT;
    else state <= state_d;

  always_ff @(posedge clk_pixel) begin
    if (rst_pixel) begin
      {de1, hs1, vs1, de2, hs2, vs2, h_seen, bad} <= '0;
      rgb1 <= '0;
      {hcnt, dcnt, vcnt, lcnt, h_active_run, h_total_run} <= '0;
      sig <= '0;
      gcnt <= '0;
      {pix_valid, pix_x, pix_y, pix_rgb, frame_done} <= '0;
      {h_active, v_active, h_total, v_total, frame_sig} <= '0;
      {frame_ok, locked, err_count} <= '0;
    end else begin
      {de1, hs1, vs1} <= {de, hsync, vsync};
      rgb1 <= {video[35:28], video[23:16], video[11:4]};
      {de2, hs2, vs2} <= {de1, hs1, vs1};
      hcnt <= hs_rise ? 12'd1 : sat_inc(hcnt);
      h_seen <= h_seen | hs_rise;
      dcnt <= de1 ? sat_inc(dcnt) : de_fall ? 12'd0 : dcnt;
      h_active_run <= hact_n;
      h_total_run <= htot_n;
      vcnt <= vs_rise ? 12'd0 : vcnt_n;
      lcnt <= vs_rise ? 12'd0 : lcnt_n;
      bad <= vs_rise ? 1'b0 : bad_n;
      sig <= sig_n;
      pix_valid <= de1;
      pix_x <= dcnt;
      pix_y <= vs_rise ? 12'd0 : lcnt;
      pix_rgb <= rgb1;
      frame_done <= emit;
      if (emit) begin
        h_active <= hact_n;
        v_active <= lcnt_n;
        h_total <= htot_n;
        v_total <= vcnt_n;
        frame_sig <= sig;
        frame_ok <= ok_n;
        gcnt <= gcnt_n;
        locked <= gcnt_n == LOCK_FRAMES;
        if (!ok_n && err_count != 8'hff) err_count <= err_count + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_nes_video_rx.sv
// tb_nes_video_rx: directed bench on a reduced 10x6 raster (8x4 active) driving nes_video_rx
module tb_nes_video_rx;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, de, hsync, vsync;
  logic [35:0] video;
  logic pix_valid, frame_done, frame_ok, locked;
  logic [11:0] pix_x, pix_y, h_active, v_active, h_total, v_total;
  logic [23:0] pix_rgb;
  logic [31:0] frame_sig;
  logic [7:0] err_count;

  nes_video_rx #(
    .EXP_H_ACTIVE(12'd8), .EXP_V_ACTIVE(12'd4), .EXP_H_TOTAL(12'd10),
    .EXP_V_TOTAL(12'd6), .LOCK_FRAMES(4'd2)
  ) dut (
    .clk_pixel(clk), .rst_pixel(rst), .de(de), .hsync(hsync), .vsync(vsync), .video(video),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .h_active(h_active), .v_active(v_active), .h_total(h_total),
    .v_total(v_total), .frame_sig(frame_sig), .frame_ok(frame_ok), .locked(locked),
    .err_count(err_count)
  );

  int checks = 0, fails = 0;
  int sx = 0, sy = 0, step_no = 0, pat = 0, skip = 0, pix_bad = 0;
  bit vs_on = 1, glitch = 0, vs_prev = 0, seen = 0, prev_de = 0;
  logic [23:0] prev_rgb = '0;
  int first_x, first_y, last_x, last_y;
  int fd_cnt = 0, fd_lat = 0, vs_step = 0, fd_before;
  logic [11:0] s_ha, s_va, s_ht, s_vt;
  logic [31:0] s_sig;
  logic s_ok, s_lock;
  logic [7:0] s_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock of a 10-clock line (de sx<8, hsync sx==8), 6-line frame (de sy<4, vsync sy==4).
  task automatic step();
    logic [23:0] rgb;
    int len;
    rgb = pat == 1 ? ((sx == 0 && sy == 0) ? 24'h000001 : 24'h0) :
          pat == 2 ? 24'hffffff : pat == 3 ? {8'(sy), 8'(sx), 8'ha5} : 24'h0;
    de = sx < 8 && sy < 4;
    hsync = sx == 8;
    vsync = vs_on && sy == 4;
    video = {rgb[23:16], 4'h0, rgb[15:8], 4'h0, rgb[7:0], 4'h0};
    if (vsync && !vs_prev) vs_step = step_no;
    vs_prev = vsync;
    @(posedge clk);
    #1;
    if (rst) skip = 1;
    else if (skip > 0) skip--;
    else if (pix_valid !== prev_de || (prev_de && pix_rgb !== prev_rgb)) pix_bad++;
    if (pix_valid === 1'b1) begin
      if (!seen) begin
        first_x = pix_x;
        first_y = pix_y;
        seen = 1;
      end
      last_x = pix_x;
      last_y = pix_y;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      fd_lat = step_no - vs_step + 1;
      {s_ha, s_va, s_ht, s_vt, s_sig} = {h_active, v_active, h_total, v_total, frame_sig};
      {s_ok, s_lock, s_err} = {frame_ok, locked, err_count};
    end
    prev_de = de;
    prev_rgb = rgb;
    step_no++;
    len = (glitch && sy == 2) ? 9 : 10;
    sx++;
    if (sx == len) begin
      sx = 0;
      if (len == 9) glitch = 0;
      sy = sy == 5 ? 0 : sy + 1;
    end
  endtask

  task automatic block();
    seen = 0;
    do step(); while (!(sx == 0 && sy == 0));
  endtask

  initial begin
    rst = 1; de = 0; hsync = 0; vsync = 0; video = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(|{pix_valid, pix_x, pix_y, pix_rgb, frame_done, h_active, v_active,
        h_total, v_total, frame_sig, frame_ok, locked, err_count}), 0);
    rst = 0;
    block();
    chk("no_fd_first_vsync", fd_cnt, 0);
    block();
    chk("fd_second_vsync", fd_cnt, 1);
    chk("h_active", s_ha, 8);
    chk("v_active", s_va, 4);
    chk("h_total", s_ht, 10);
    chk("v_total", s_vt, 6);
    chk("frame_ok", s_ok, 1);
    chk("sig_zero", s_sig, 0);
    chk("not_locked_1st", s_lock, 0);
    chk("err_zero", s_err, 0);
    chk("frame_latency", fd_lat, 2);
    block();
    chk("locked_2nd", s_lock, 1);
    block();
    chk("locked_hold", s_lock, 1);
    chk("fd_count", fd_cnt, 3);
    pat = 1;
    block();
    chk("sig_single", s_sig, 32'h80000000);
    pat = 2;
    block();
    chk("sig_ones", s_sig, 32'h00000000);
    chk("ok_ones", s_ok, 1);
    pat = 3;
    block();
    chk("first_x", first_x, 0);
    chk("first_y", first_y, 0);
    chk("last_x", last_x, 7);
    chk("last_y", last_y, 3);
    chk("pix_stream", pix_bad, 0);
    pat = 0;
    glitch = 1;
    block();
    chk("glitch_ok", s_ok, 0);
    chk("glitch_locked", s_lock, 0);
    chk("glitch_err", s_err, 1);
    chk("glitch_h_total", s_ht, 9);
    block();
    chk("relock_ok", s_ok, 1);
    chk("relock_not_yet", s_lock, 0);
    block();
    chk("relock_2nd", s_lock, 1);
    repeat (23) step();
    rst = 1;
    step();
    chk("midrst_outputs", 32'(|{pix_valid, pix_x, pix_y, pix_rgb, frame_done, h_active, v_active,
        h_total, v_total, frame_sig, frame_ok}), 0);
    chk("midrst_locked", locked, 0);
    chk("midrst_err", err_count, 0);
    rst = 0;
    fd_before = fd_cnt;
    block();
    chk("midrst_no_fd", fd_cnt, fd_before);
    block();
    chk("midrst_fd", fd_cnt, fd_before + 1);
    chk("midrst_ok", s_ok, 1);
    chk("midrst_not_locked", s_lock, 0);
    chk("midrst_err_frame", s_err, 0);
    block();
    chk("midrst_relock", s_lock, 1);
    vs_on = 0;
    fd_before = fd_cnt;
    repeat (683) block();
    chk("novs_no_fd", fd_cnt, fd_before);
    vs_on = 1;
    block();
    chk("novs_fd", fd_cnt, fd_before + 1);
    chk("novs_ok", s_ok, 0);
    chk("novs_v_total", s_vt, 12'd4095);
    chk("novs_v_active", s_va, 2736);
    chk("novs_err", s_err, 1);
    chk("novs_locked", s_lock, 0);
    chk("pix_stream_final", pix_bad, 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
